// File: rtl/fifo_reader.sv
// Drains words from the FIFO read port and serializes each one into OUT_W-bit beats,
// least-significant beat first, on a valid/ready stream. Counts words popped since reset.
module fifo_reader #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OUT_W = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             pnding_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             pop_o,
    output logic [OUT_W-1:0] out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             out_last_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] word_cnt_o
);

    localparam int unsigned BEATS  = WIDTH / OUT_W;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic {StIdle, StSend} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic in_send;
    logic last_beat;
    logic accept;
    logic pop;

    assign in_send   = (state_q == StSend);
    assign last_beat = (beat_q == BEAT_W'(BEATS - 1));
    assign accept    = in_send && out_ready_i;

    // Reset gates the pop so the FIFO never loses a word while this block is held in reset.
    assign pop = rst_i && pnding_i && (in_send ? (accept && last_beat) : 1'b1);

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        beat_d  = beat_q;
        cnt_d   = cnt_q + CNT_W'(pop);

        if (!in_send) begin
            if (pnding_i) begin
                shreg_d = data_i;
                beat_d  = '0;
                state_d = StSend;
            end
        end else if (accept) begin
            if (!last_beat) begin
                shreg_d = shreg_q >> OUT_W;
                beat_d  = beat_q + BEAT_W'(1);
            end else if (pnding_i) begin
                shreg_d = data_i;
                beat_d  = '0;
            end else begin
                state_d = StIdle;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
            shreg_q <= '0;
            beat_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            beat_q  <= beat_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pop_o       = pop;
    assign out_valid_o = in_send;
    assign busy_o      = in_send;
    assign out_data_o  = in_send ? shreg_q[OUT_W-1:0] : '0;
    assign out_last_o  = in_send && last_beat;
    assign word_cnt_o  = cnt_q;

endmodule

// File: doc/fifo_reader.md
# fifo_reader

Consumer-side drain engine for the `fifo_top` word buffer. It watches the buffer's pending flag and pops one WIDTH-bit word at a time. Each word is serialized into OUT_W-bit beats on a valid/ready stream, least-significant beat first. The block sits between the FIFO's read port and any narrower downstream sink, and keeps a running count of words drained.

## Interface
- `WIDTH`, 32, FIFO word width; must be an integer multiple of OUT_W.
- `OUT_W`, 8, output beat width; BEATS = WIDTH/OUT_W (BEATS ≥ 1).
- `CNT_W`, 16, width of the drained-word counter.

Ports:
- `clk_i`  in  1  single clock, all state on rising edge.
- `rst_i`  in  1  reset, synchronous, active-low.
- `pnding_i`  in  1  FIFO holds ≥1 word; `data_i` is valid while high.
- `data_i`  in  WIDTH  oldest FIFO word, combinational from FIFO.
- `pop_o`  out  1  one-cycle pop strobe to FIFO.
- `out_data_o`  out  OUT_W  current beat.
- `out_valid_o`  out  1  beat valid.
- `out_ready_i`  in  1  sink accepts beat.
- `out_last_o`  out  1  current beat is last of its word.
- `busy_o`  out  1  word in flight (state SEND).
- `word_cnt_o`  out  CNT_W  words popped since reset, wraps.

## Operation
- Storage:
  - shift register `shreg` (WIDTH), holding the word being sent.
  - beat index `beat` ($clog2(BEATS), min 1 bit).
  - state IDLE/SEND.
  - counter.
- IDLE:
  - `pop_o` = `pnding_i`.
  - When `pnding_i`=1: capture `data_i` into `shreg` at the same edge, `beat`←0, go to SEND.
- SEND:
  - `out_valid_o`=1 and `out_data_o`=`shreg[OUT_W-1:0]`.
  - `out_last_o`=(`beat`==BEATS-1).
  - `pop_o`=0, except in the final-beat case below.
- Beat accepted (`out_valid_o`&`out_ready_i`), not last: `shreg` shifts right by OUT_W, `beat`+1.
- Beat accepted, last:
  - If `pnding_i`=1: `pop_o`=1 this cycle. Load `data_i`, `beat`←0, stay in SEND (back-to-back, no bubble).
  - Else: go to IDLE.
- Stall: while `out_valid_o`=1 and `out_ready_i`=0, `out_data_o`, `out_last_o` and `shreg` hold stable. `out_valid_o` never drops before acceptance.
- `word_cnt_o` increments by 1 on every cycle `pop_o`=1. It wraps 2^CNT_W-1→0.
- `busy_o`=1 exactly when state is SEND.
- Combinational paths:
  - `pop_o` is combinational from state, `pnding_i`, `out_ready_i`, `beat`.
  - `pop_o` never depends on `data_i`.
- No pop is ever issued while `pnding_i`=0.

## Timing
- Reset (`rst_i`=0 at an edge):
  - state IDLE, `shreg`=0, `beat`=0, `word_cnt_o`=0.
  - Hence `pop_o`=0, `out_valid_o`=0, `out_last_o`=0, `out_data_o`=0, `busy_o`=0.
  - Reset has priority over every event.
- Reset mid-word: any remaining beats are discarded. No pop is issued in the reset cycle, even if `pnding_i`=1.
- Latency:
  - Pop cycle N → first beat valid at cycle N+1.
  - With `out_ready_i` held high, one word takes exactly BEATS cycles of `out_valid_o`.
- Throughput: with `pnding_i` and `out_ready_i` held high, `out_valid_o` stays high continuously and `pop_o` pulses once every BEATS cycles.
- BEATS=1: every beat is last. `out_last_o` is held high in SEND.
- FIFO goes empty on the same cycle as a final-beat accept: no pop, return to IDLE, `out_valid_o`=0 the next cycle.

## Test plan
- Reset/idle:
  - Assert `rst_i`=0 for 2 cycles with `pnding_i`=1: `pop_o`=0 throughout and all outputs 0.
  - Release reset: `pop_o`=1 in the first cycle after release.
- Single word, WIDTH=32/OUT_W=8, `data_i`=0xA1B2C3D4, ready high:
  - one `pop_o` pulse, then beats D4,C3,B2,A1 on 4 consecutive cycles.
  - `out_last_o` only on A1; `word_cnt_o`=1.
- Back-to-back: push 0x11223344 and 0x55667788, ready high.
  - 8 continuous valid beats: 44,33,22,11,88,77,66,55.
  - second pop coincides with beat 11; `word_cnt_o`=2.
- Backpressure: ready toggles 1,0,0,1,… on word 0xDEADBEEF.
  - Beats EF,BE,AD,DE in order; data stable during every stall; no extra pops.
- Reset mid-word: assert reset after beat 2 of 0x01020304.
  - Next cycle `out_valid_o`=0 and `word_cnt_o`=0; a subsequent word is sent from beat 0.
- Counter wrap, CNT_W=4: drain 17 words.
  - `word_cnt_o` goes 15→0→1; all words delivered intact.
